// File: rtl/ir_nec_pkg.sv
// Shared NEC transmitter types and timing constants.
// The repeat-code states are always declared; they are only used when IR_NEC_REPEAT_EN is defined.
`timescale 1ns/1ps
package ir_nec_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LEADER_MARK,
    LEADER_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP,
    REP_MARK,
    REP_SPACE
  } state_t;

  localparam int unsigned LEADER_MARK_U  = 16;
  localparam int unsigned LEADER_SPACE_U = 8;
  localparam int unsigned BIT_MARK_U     = 1;
  localparam int unsigned ZERO_SPACE_U   = 1;
  localparam int unsigned ONE_SPACE_U    = 3;
  localparam int unsigned STOP_U         = 1;
  localparam int unsigned REP_SPACE_U    = 4;
  localparam int unsigned FRAME_PERIOD_U = 192;
  localparam int unsigned NEC_BITS       = 32;

  // Index of the last unit tick in a segment; GAP is timed by the frame-period counter instead.
  function automatic logic [4:0] seg_last(state_t s, logic bit_val);
    case (s)
      LEADER_MARK:  return 5'(LEADER_MARK_U - 1);
      LEADER_SPACE: return 5'(LEADER_SPACE_U - 1);
      BIT_MARK:     return 5'(BIT_MARK_U - 1);
      BIT_SPACE:    return bit_val ? 5'(ONE_SPACE_U - 1) : 5'(ZERO_SPACE_U - 1);
      STOP_MARK:    return 5'(STOP_U - 1);
      REP_MARK:     return 5'(LEADER_MARK_U - 1);
      REP_SPACE:    return 5'(REP_SPACE_U - 1);
      default:      return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ir_unit_timer.sv
// Free-running NEC unit timer: counts 0..UNIT_CYC-1 and pulses tick on the terminal count.
// clear forces the count back to 0 so every segment starts on a fresh unit.
`timescale 1ns/1ps
module ir_unit_timer #(
  parameter int unsigned UNIT_CYC = 28125
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned W = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(UNIT_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/ir_nec_tx.sv
// NEC frame transmitter: leader, 32 LSB-first data bits and a stop burst gating the carrier.
// Optional repeat codes are built when IR_NEC_REPEAT_EN is defined.
`timescale 1ns/1ps
module ir_nec_tx import ir_nec_pkg::*; #(
  parameter int unsigned FCLK = 50_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] cmd,
  input  logic       nec_clk,
  output logic       ir_out,
  output logic       busy,
  output logic       done
);

  localparam int unsigned UNIT_CYC = (FCLK * 32'd9) / 32'd16000;

  state_t      state;
  logic        mark;
  logic [31:0] shreg;
  logic [5:0]  bit_cnt;
  logic [4:0]  seg_cnt;
  logic        tick;
  logic        seg_end;
  logic        gap_end;
  logic        timer_clear;

  assign seg_end = tick && (state != IDLE) && (state != GAP) &&
                   (seg_cnt == seg_last(state, shreg[0]));

`ifdef IR_NEC_REPEAT_EN
  logic [7:0] period_cnt;

  assign gap_end = (state == GAP) && tick && (period_cnt == 8'(FRAME_PERIOD_U - 1));

  // Units elapsed since the current leader or repeat burst began.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt <= '0;
    end else if (state == IDLE || gap_end) begin
      period_cnt <= '0;
    end else if (tick) begin
      period_cnt <= period_cnt + 8'd1;
    end
  end
`else
  assign gap_end = 1'b0;
`endif

  assign timer_clear = (state == IDLE) || seg_end || gap_end;

  ir_unit_timer #(
    .UNIT_CYC (UNIT_CYC)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .tick    (tick)
  );

  // Registered mark keeps FSM decode glitches off the LED pin.
  assign ir_out = nec_clk & mark;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      mark    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
      seg_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (seg_end) begin
        seg_cnt <= '0;
      end else if (tick) begin
        seg_cnt <= seg_cnt + 5'd1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= {~cmd, cmd, ~addr, addr};
            bit_cnt <= '0;
            seg_cnt <= '0;
            busy    <= 1'b1;
            mark    <= 1'b1;
            state   <= LEADER_MARK;
          end
        end
        LEADER_MARK: begin
          if (seg_end) begin
            mark  <= 1'b0;
            state <= LEADER_SPACE;
          end
        end
        LEADER_SPACE: begin
          if (seg_end) begin
            mark  <= 1'b1;
            state <= BIT_MARK;
          end
        end
        BIT_MARK: begin
          if (seg_end) begin
            mark  <= 1'b0;
            state <= BIT_SPACE;
          end
        end
        BIT_SPACE: begin
          if (seg_end) begin
            shreg   <= {1'b0, shreg[31:1]};
            bit_cnt <= bit_cnt + 6'd1;
            mark    <= 1'b1;
            state   <= (bit_cnt == 6'(NEC_BITS - 1)) ? STOP_MARK : BIT_MARK;
          end
        end
        STOP_MARK: begin
          if (seg_end) begin
            done <= 1'b1;
            mark <= 1'b0;
`ifdef IR_NEC_REPEAT_EN
            state <= GAP;
`else
            busy  <= 1'b0;
            state <= IDLE;
`endif
          end
        end
`ifdef IR_NEC_REPEAT_EN
        GAP: begin
          if (gap_end) begin
            if (start) begin
              mark  <= 1'b1;
              state <= REP_MARK;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        REP_MARK: begin
          if (seg_end) begin
            mark  <= 1'b0;
            state <= REP_SPACE;
          end
        end
        REP_SPACE: begin
          if (seg_end) begin
            mark  <= 1'b1;
            state <= STOP_MARK;
          end
        end
`endif
        default: begin
          mark  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ir_nec_tx.sv
// Randomized self-checking bench for ir_nec_tx at FCLK=16000 (9 cycles per NEC unit).
// Expected envelopes come from a segment-list model; received words are decoded from ir_out gaps.
`timescale 1ns/1ps
module tb_ir_nec_tx;

  localparam int UNIT = 9;
  localparam int MAXC = 2400;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] addr;
  logic [7:0] cmd;
  logic       nec_clk;
  logic       ir_out;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  logic obs_ir   [0:MAXC];
  logic obs_nec  [0:MAXC];
  logic obs_busy [0:MAXC];
  logic obs_done [0:MAXC];
  int   n_cap;
  bit   exp_q [$];

  ir_nec_tx #(
    .FCLK (16000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .addr    (addr),
    .cmd     (cmd),
    .nec_clk (nec_clk),
    .ir_out  (ir_out),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Carrier: high one cycle in three, changing just after each rising edge.
  initial begin
    int ph;
    ph = 0;
    nec_clk = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph = (ph == 2) ? 0 : ph + 1;
      nec_clk = (ph == 0);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Mark/space envelope of one frame, one entry per clock after the start edge.
  function automatic void buildEnvelope(input logic [31:0] word);
    exp_q.delete();
    repeat (16 * UNIT) exp_q.push_back(1'b1);
    repeat (8 * UNIT) exp_q.push_back(1'b0);
    for (int i = 0; i < 32; i++) begin
      repeat (UNIT) exp_q.push_back(1'b1);
      repeat ((word[i] ? 3 : 1) * UNIT) exp_q.push_back(1'b0);
    end
    repeat (UNIT) exp_q.push_back(1'b1);
  endfunction

  // Long gaps between carrier pulses are spaces: the first is the leader, then one per bit.
  function automatic logic [31:0] decodeWord(input int n);
    int          gap;
    int          nsp;
    bit          seen;
    logic [31:0] w;
    gap = 0; nsp = 0; seen = 0; w = '0;
    for (int j = 1; j <= n; j++) begin
      if (obs_ir[j] === 1'b1) begin
        if (seen && gap > 4) begin
          if (nsp >= 1 && nsp <= 32) w[nsp-1] = (gap >= 20);
          nsp++;
        end
        seen = 1; gap = 0;
      end else begin
        gap++;
      end
    end
    return w;
  endfunction

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] c, input bit perturb);
    logic [31:0] word;
    int busy_len, done_pos, done_cnt, env_err;
    bit em;
    word = {~c, c, ~a, a};
    start = 1'b1; addr = a; cmd = c;
    n_cap = 0;
    for (int j = 1; j <= 1200; j++) begin
      @(negedge clk);
      obs_ir[j] = ir_out; obs_nec[j] = nec_clk;
      obs_busy[j] = busy; obs_done[j] = done;
      n_cap = j;
      if (perturb && j < 1000) begin
        start = 1'($urandom_range(0, 1));
        addr = 8'($urandom); cmd = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      if (!busy) break;
    end
    start = 1'b0;
    buildEnvelope(word);
    busy_len = 0; done_pos = 0; done_cnt = 0; env_err = 0;
    for (int j = 1; j <= n_cap; j++) begin
      if (obs_busy[j] === 1'b1) busy_len++;
      if (obs_done[j] === 1'b1) begin
        done_cnt++;
        if (done_pos == 0) done_pos = j;
      end
      em = (j <= exp_q.size()) ? exp_q[j-1] : 1'b0;
      if (obs_ir[j] !== (obs_nec[j] & em)) env_err++;
    end
    checkOutput("busy_len", busy_len, exp_q.size());
    checkOutput("done_pos", done_pos, exp_q.size() + 1);
    checkOutput("done_cnt", done_cnt, 1);
    checkOutput("envelope_err", env_err, 0);
    checkOutput("word", decodeWord(n_cap), word);
    @(negedge clk);
  endtask

  task automatic startPulse(input logic [7:0] a, input logic [7:0] c);
    start = 1'b1; addr = a; cmd = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic resetRecover(input string tag);
    int dcnt, bcnt;
    @(negedge clk);
    reset_n = 1'b1;
    dcnt = 0; bcnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    checkOutput({tag, "_no_done"}, dcnt, 0);
    checkOutput({tag, "_stay_idle"}, bcnt, 0);
  endtask

  initial begin
    logic [31:0] word;
    int off, d1, d2;
    logic b1090, b1091, b_end;

    reset_n = 1'b0; start = 1'b0; addr = '0; cmd = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_ir", ir_out, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] frame addr=00 cmd=FF");
    applyStimulus(8'h00, 8'hFF, 1'b0);
    $display("[TB] frame addr=A5 cmd=3C");
    applyStimulus(8'hA5, 8'h3C, 1'b0);
    $display("[TB] frame with inputs changing mid-frame");
    applyStimulus(8'h5E, 8'h91, 1'b1);
    for (int r = 0; r < 3; r++) begin
      applyStimulus(8'($urandom), 8'($urandom), 1'b0);
    end

    $display("[TB] reset during bit 10 space");
    word = {~8'h3C, 8'h3C, ~8'hA5, 8'hA5};
    off = 24 * UNIT;
    for (int i = 0; i < 10; i++) off += UNIT + (word[i] ? 3 : 1) * UNIT;
    off += UNIT;
    startPulse(8'hA5, 8'h3C);
    repeat (off + 3) @(negedge clk);
    checkOutput("pre_abort_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_ir", ir_out, 0);
    resetRecover("abort1");
    applyStimulus(8'hA5, 8'h3C, 1'b0);

    $display("[TB] reset during leader mark");
    startPulse(8'h33, 8'hCC);
    for (int k = 0; k < 4 && !nec_clk; k++) @(negedge clk);
    checkOutput("pre_abort_ir", ir_out, 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("abort2_ir", ir_out, 0);
    checkOutput("abort2_busy", busy, 0);
    resetRecover("abort2");

    $display("[TB] back-to-back frames");
    buildEnvelope({~8'h34, 8'h34, ~8'h12, 8'h12});
    start = 1'b1; addr = 8'h12; cmd = 8'h34;
    d1 = 0; d2 = 0; b1090 = 1'bx; b1091 = 1'bx; b_end = 1'bx;
    for (int j = 1; j <= 2300; j++) begin
      @(negedge clk);
      if (done) begin
        if (d1 == 0) d1 = j;
        else if (d2 == 0) d2 = j;
      end
      if (j == exp_q.size() + 1) b1090 = busy;
      if (j == exp_q.size() + 2) b1091 = busy;
      if (j == 2300) b_end = busy;
      if (j == 1100) start = 1'b0;
    end
    checkOutput("b2b_done1", d1, exp_q.size() + 1);
    checkOutput("b2b_spacing", d2 - d1, exp_q.size() + 1);
    checkOutput("b2b_gap_idle", b1090, 0);
    checkOutput("b2b_restart", b1091, 1);
    checkOutput("b2b_end_idle", b_end, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
